// File: rtl/rv32_fetch_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | rv32_fetch_pkg : shared types and constants for instruction fetch |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
package rv32_fetch_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_pc_next.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_pc_next : next-PC select, JALR bit-0 mask, misalign detect  |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module fetch_pc_next (
  input  logic [31:0] pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] next_pc,
  output logic        misaligned
);
  import rv32_fetch_pkg::*;

  logic [XLEN-1:0] target;

  // Bit 0 is always cleared (JALR rule); a remaining bit 1 means a half-word target.
  assign target     = {redirect_pc[XLEN-1:1], 1'b0};
  assign next_pc    = redirect_valid ? target : pc + XLEN'(4);
  assign misaligned = redirect_valid & target[1];

endmodule
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | inst_fetch_unit : PC owner, single-outstanding imem fetch FSM     |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module inst_fetch_unit #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = rv32_fetch_pkg::DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_pc_plus4,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_fault
);
  import rv32_fetch_pkg::*;

  fetch_state_e    state;
  fetch_state_e    state_next;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next_sel;
  logic            misaligned;
  logic            consume;
  logic            capture;

  assign consume       = inst_valid & inst_ready;
  assign capture       = (state == S_WAIT) & imem_resp_valid;
  assign imem_req_addr = pc;
  assign inst_pc_plus4 = inst_pc + XLEN'(4);

  fetch_pc_next u_pc_next (
    .pc             (pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .next_pc        (pc_next_sel),
    .misaligned     (misaligned)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_REQ;
    else     state <= state_next;
  end

  always_comb begin
    state_next     = state;
    imem_req_valid = 1'b0;
    case (state)
      S_REQ: begin
        imem_req_valid = ~rst;
        if (imem_req_ready) state_next = S_WAIT;
      end
      S_WAIT:  if (imem_resp_valid) state_next = S_HOLD;
      S_HOLD:  if (consume) state_next = misaligned ? S_FAULT : S_REQ;
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_REQ;
    endcase
  end

  // redirect inputs only matter on the consuming edge
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      inst        <= NOP_INST;
      inst_pc     <= RESET_PC;
      inst_valid  <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      if (capture) begin
        inst       <= imem_resp_data;
        inst_pc    <= pc;
        inst_valid <= 1'b1;
      end
      if ((state == S_HOLD) && consume) begin
        inst_valid <= 1'b0;
        pc         <= pc_next_sel;
        if (misaligned) fetch_fault <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | tb_inst_fetch_unit : scoreboard bench with PC reference model     |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
module tb_inst_fetch_unit;
  import rv32_fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  always #5 clk = ~clk;

  inst_fetch_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_pc_plus4   (inst_pc_plus4),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .fetch_fault     (fetch_fault)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_pc = RST_PC;
  logic [31:0] tgt;
  bit          exp_fault = 0;
  bit          directed = 1;
  bit          quiet = 0;
  int          n_acc = 0;
  int          n_cons = 0;
  int          cycle = 0;
  int          last_rise = 0;
  bit          acc_flag = 0;
  logic [31:0] acc_addr;
  bit          rst_at_edge = 0;
  bit          prev_valid = 0;
  bit          mem_pend = 0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr;
  int          stall = 0;
  int          bp = 0;
  int          wd;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h00A0_0113;
      32'h8:   return 32'h0020_81B3;
      default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  always @(posedge clk) begin
    rst_at_edge = rst;
    cycle = cycle + 1;
  end

  // Monitor: model the PC stream from the fetch rules and compare.
  always @(negedge clk) begin
    if (rst) check("req_valid_in_reset", 32'(imem_req_valid), 32'd0);
    if (rst_at_edge) begin
      check("rst_inst_valid", 32'(inst_valid), 32'd0);
      check("rst_fetch_fault", 32'(fetch_fault), 32'd0);
      check("rst_inst_nop", inst, NOP_INST);
      check("rst_inst_pc", inst_pc, RST_PC);
      if (!rst) begin
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_req_addr", imem_req_addr, RST_PC);
      end
      model_pc   = RST_PC;
      sb.delete();
      exp_fault  = 0;
      prev_valid = 0;
    end
    if (!rst) begin
      if (exp_fault) begin
        check("fault_sticky", 32'(fetch_fault), 32'd1);
        check("no_req_in_fault", 32'(imem_req_valid), 32'd0);
        check("no_inst_in_fault", 32'(inst_valid), 32'd0);
      end else begin
        check("fetch_fault_clear", 32'(fetch_fault), 32'd0);
        if (inst_valid) begin
          if (sb.size() == 0) begin
            check("inst_valid_without_request", 32'(inst_valid), 32'd0);
          end else begin
            check("inst_data", inst, sb[0].data);
            check("inst_pc", inst_pc, sb[0].pc);
            check("inst_pc_plus4", inst_pc_plus4, sb[0].pc + 32'd4);
            if (!prev_valid) begin
              if (directed && (n_cons == 1 || n_cons == 2))
                check("issue_interval", 32'(cycle - last_rise), 32'd3);
              last_rise = cycle;
            end
            if (inst_ready) begin
              void'(sb.pop_front());
              n_cons++;
              if (redirect_valid) begin
                tgt = redirect_pc & ~32'h1;
                if (tgt[1]) exp_fault = 1;
                else        model_pc  = tgt;
              end else begin
                model_pc = model_pc + 32'd4;
              end
            end
          end
        end
        if (imem_req_valid) begin
          check("req_addr", imem_req_addr, model_pc);
          check("single_outstanding", 32'(sb.size()), 32'd0);
          if (imem_req_ready) begin
            sb.push_back('{model_pc, mem_word(model_pc)});
            n_acc++;
            acc_flag = 1;
            acc_addr = imem_req_addr;
          end
        end
      end
    end
    prev_valid = inst_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = $urandom;
    if (acc_flag) begin
      acc_flag = 0;
      mem_pend = 1;
      mem_addr = acc_addr;
      mem_cnt  = directed ? ((n_acc == 4) ? 4 : 1) : int'($urandom_range(1, 4));
    end
    if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(mem_addr);
        mem_pend        = 0;
      end
    end
    if (directed) begin
      imem_req_ready = 1'b1;
      if (n_acc == 3 && imem_req_valid && stall < 3) begin
        imem_req_ready = 1'b0;
        stall++;
      end
      inst_ready = 1'b1;
      if (n_cons == 2 && inst_valid && bp < 5) begin
        inst_ready = 1'b0;
        bp++;
      end
      redirect_valid = 1'b0;
      redirect_pc    = $urandom;
      if (!inst_ready) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0556;
      end else begin
        case (n_cons)
          2: begin redirect_valid = 1'b1; redirect_pc = 32'h0000_0101; end
          3: begin redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; end
          5: begin redirect_valid = 1'b1; redirect_pc = 32'h0000_0102; end
          default: ;
        endcase
      end
    end else begin
      imem_req_ready = ($urandom_range(0, 2) != 0);
      inst_ready     = ($urandom_range(0, 2) != 0);
      redirect_valid = !quiet && ($urandom_range(0, 3) == 0);
      redirect_pc    = $urandom & ~32'h3;
      if ($urandom_range(0, 15) == 0) redirect_pc[1:0] = 2'($urandom);
      else if ($urandom_range(0, 1) == 0) redirect_pc[0] = 1'b1;
    end
  endtask

  task automatic do_reset(input int n);
    rst             = 1'b1;
    imem_resp_valid = 1'b0;
    imem_req_ready  = 1'b0;
    inst_ready      = 1'b0;
    redirect_valid  = 1'b0;
    mem_pend        = 0;
    acc_flag        = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  initial begin
    imem_resp_data = 32'h0;
    redirect_pc    = 32'h0;
    do_reset(2);

    wd = 0;
    while (!exp_fault && wd < 300) begin
      step();
      wd++;
    end
    check("directed_consumptions", 32'(n_cons), 32'd6);
    repeat (6) step();

    directed = 0;
    do_reset(2);
    for (int i = 0; i < 4000; i++) begin
      if (exp_fault) begin
        repeat (4) step();
        do_reset(2);
      end else if (mem_pend && $urandom_range(0, 149) == 0) begin
        do_reset(1);
      end else begin
        step();
      end
    end
    check("random_progress", 32'(n_cons > 100), 32'd1);

    quiet = 1;
    if (exp_fault) do_reset(2);
    wd = 0;
    while (!mem_pend && wd < 200) begin
      step();
      wd++;
    end
    check("reached_wait_state", 32'(mem_pend), 32'd1);
    do_reset(1);
    repeat (30) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Upstream neighbour of the decode/control stage. Owns the program counter and fetches 32-bit instructions from instruction memory over a valid/ready request channel and a valid-only response channel.
- Presents one instruction at a time to decode through an `inst_valid`/`inst_ready` handshake.
- Applies the taken-branch/jump redirect (controller `PCSel` plus ALU target) when the instruction is consumed.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- XLEN, 32, address/data width; only 32 is supported.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  32  fetch address, word-aligned.
- imem_resp_valid  in  1  response data valid; one per accepted request, latency ≥1 cycle.
- imem_resp_data  in  32  fetched instruction word.
- inst_valid  out  1  `inst`/`inst_pc` hold a fetched instruction.
- inst_ready  in  1  decode/execute consumes the instruction this cycle.
- inst  out  32  instruction to the controller.
- inst_pc  out  32  address of `inst`.
- inst_pc_plus4  out  32  `inst_pc`+4, the PC+4 writeback source.
- redirect_valid  in  1  `PCSel` from the controller for the instruction being consumed.
- redirect_pc  in  32  branch/jump target from the ALU.
- fetch_fault  out  1  sticky misaligned-target fault.

Behaviour:
- Reset is synchronous and active-high. When `rst` is high at a rising edge, the following take effect at that edge:
  - state = S_REQ, pc = RESET_PC
  - inst = 32'h0000_0013 (NOP), inst_pc = RESET_PC, inst_valid = 0, fetch_fault = 0
  - Combinational outputs during reset: imem_req_valid = 0.
- States S_REQ, S_WAIT, S_HOLD and S_FAULT; one outstanding request maximum.
- S_REQ:
  - imem_req_valid = 1 and imem_req_addr = pc, both combinational from state.
  - If imem_req_ready = 1, go to S_WAIT next cycle; otherwise stay, holding the address stable.
- S_WAIT:
  - On imem_resp_valid = 1: capture `inst` = imem_resp_data, `inst_pc` = pc; set inst_valid = 1; go to S_HOLD.
  - imem_resp_valid in any other state is ignored and is a bench error.
- S_HOLD:
  - inst_valid = 1; `inst` and `inst_pc` are stable until consumed.
  - Consumption is inst_valid & inst_ready. On consumption: inst_valid = 0 next cycle and state goes to S_REQ.
  - Next pc = {redirect_pc[31:1],1'b0} if redirect_valid, else pc+4.
  - redirect_valid is sampled only on consumption and is ignored otherwise.
- Misaligned target:
  - On a redirect whose masked target has bits [1] ≠ 0, go to S_FAULT instead of S_REQ and set fetch_fault = 1.
- S_FAULT: no requests and inst_valid = 0. Only rst exits this state.
- Arithmetic:
  - pc+4 and inst_pc_plus4 are modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0.
  - inst_pc_plus4 is combinational from inst_pc.
- Latency and throughput:
  - First imem_req_valid occurs in the first cycle after rst deasserts.
  - With 1-cycle memory and inst_ready tied high, inst_valid pulses once every 3 cycles.
- Reset mid-operation: an in-flight request is abandoned. Instruction memory shares `rst`, so no pre-reset response arrives after reset.

Decomposition:
- Package `rv32_fetch_pkg` holds:
  - the state enum {S_REQ, S_WAIT, S_HOLD, S_FAULT}
  - XLEN
  - NOP_INST = 32'h0000_0013
  - the default RESET_PC
- One natural sub-module, `fetch_pc_next`: combinational next-PC select, JALR bit-0 masking and misalignment detection. The FSM and registers stay in the top module.

Test Plan:
- Reset and sequential fetch: rst for 2 cycles; memory returns 0x00500093, 0x00A00113, 0x002081B3 at 1-cycle latency; inst_ready = 1 → imem_req_addr sequence 0x0, 0x4, 0x8; inst_pc 0x0/0x4/0x8; inst_pc_plus4 0x4/0x8/0xC; one inst_valid pulse every 3 cycles.
- Backpressure: inst_ready = 0 for 5 cycles in S_HOLD → inst/inst_pc stable, no new request; after consumption, next request at pc+4.
- Request stall and latency: imem_req_ready low 3 cycles, then response latency 4 → imem_req_addr held constant; exactly one capture.
- Taken redirect: consume the instruction at 0x8 with redirect_valid = 1, redirect_pc = 0x101 → next imem_req_addr = 0x100 (bit 0 cleared); redirect_valid pulsed while not consuming → ignored.
- Misaligned: redirect_pc = 0x102 on consumption → fetch_fault = 1, no further imem_req_valid and inst_valid = 0 until rst; after rst, fetch_fault = 0 and fetch restarts at RESET_PC.
- Wrap and mid-reset: pc = 0xFFFF_FFFC fetched → inst_pc_plus4 = 0x0, next request 0x0; rst asserted in S_WAIT → next cycle imem_req_valid = 0 and inst_valid = 0, then fetch from RESET_PC.
